// File: rtl/project_select_pkg.sv
// Shared types and register map for the project selection controller.
// Optional feature macro used by this block: PROJ_SEL_LOCK_EN.
package project_select_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_GUARD = 3'd2,
        ST_PRST  = 3'd3
    } state_t;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int unsigned SEL_W         = 5;
    localparam int unsigned CTRL_LOCK_BIT = 31;
    localparam int unsigned ST_STATE_LSB  = 8;
    localparam int unsigned ST_STATE_W    = 3;
    localparam int unsigned ST_BUSY_BIT   = 11;
    localparam int unsigned ST_DROP_BIT   = 12;
    localparam int unsigned ST_LOCK_BIT   = 13;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/project_select_if.sv
// Wishbone slave bus bundle for the project selection controller.
interface project_select_if;

    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_addr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_addr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_addr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/project_select_wb_regs.sv
// Address decode, single-cycle ack and CTRL/STATUS register file.
// Lock request is always decoded; the top decides whether it has any effect.
module project_select_wb_regs
    import project_select_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [4:0]  RESET_SEL = 5'd0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    project_select_if.slave  bus,
    input  logic [SEL_W-1:0] cur_sel,
    input  state_t           state,
    input  logic             busy,
    input  logic             dropped,
    input  logic             locked,
    output logic             ctrl_wr,
    output logic [SEL_W-1:0] ctrl_sel,
    output logic             lock_req
);

    localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

    logic             hit_ctrl;
    logic             hit_status;
    logic             req;
    logic [SEL_W-1:0] pend_sel;
    logic [31:0]      status_word;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign hit_ctrl   = (bus.wbs_addr_i[31:2] == CTRL_ADDR[31:2]);
    assign hit_status = (bus.wbs_addr_i[31:2] == STATUS_ADDR[31:2]);
    assign req        = bus.wb_cyc_i & bus.wb_stb_i & (hit_ctrl | hit_status) & ~bus.wbs_ack_o;

    assign ctrl_wr  = req & bus.wbs_we_i & hit_ctrl & bus.wbs_sel_i[0];
    assign ctrl_sel = bus.wbs_dat_i[SEL_W-1:0];
    assign lock_req = req & bus.wbs_we_i & hit_ctrl & bus.wbs_sel_i[3] & bus.wbs_dat_i[CTRL_LOCK_BIT];

    assign unused_bits = ^{bus.wbs_dat_i[30:5], bus.wbs_addr_i[1:0], bus.wbs_sel_i[2:1]};

    // Assemble the STATUS word from live controller state
    always_comb begin
        status_word                              = '0;
        status_word[SEL_W-1:0]                   = cur_sel;
        status_word[ST_STATE_LSB +: ST_STATE_W]  = state;
        status_word[ST_BUSY_BIT]                 = busy;
        status_word[ST_DROP_BIT]                 = dropped;
        status_word[ST_LOCK_BIT]                 = locked;
        rd_data = hit_ctrl ? {{(32-SEL_W){1'b0}}, pend_sel} : status_word;
    end

    // Ack one cycle after each request; read data only present with ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
        end else begin
            bus.wbs_ack_o <= req;
            bus.wbs_dat_o <= (req && !bus.wbs_we_i) ? rd_data : '0;
        end
    end

    // Last written selection, kept even when the switch request is dropped
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pend_sel <= RESET_SEL;
        end else if (ctrl_wr) begin
            pend_sel <= ctrl_sel;
        end
    end

endmodule

// File: rtl/project_select_ctrl.sv
// Selects which wrapped user project owns the shared Caravel resources and
// sequences switchover: deactivate -> drain WB -> guard gap -> reset -> run.
// Optional feature: PROJ_SEL_LOCK_EN (one-way lock of the current selection).
module project_select_ctrl
    import project_select_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned DEFAULT_SEL  = 0,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned RESET_CYCLES = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    project_select_if.slave         bus,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic [NUM_PROJECTS-1:0] proj_rst_o,
    output logic                    busy_o
);

    localparam int unsigned CNT_W   = $clog2(max_u(GUARD_CYCLES, RESET_CYCLES) + 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    // Out-of-range defaults collapse to 31, which selects nothing for <32 projects
    localparam logic [SEL_W-1:0] DEF_SEL = (DEFAULT_SEL > 31) ? 5'd31 : 5'(DEFAULT_SEL);

    state_t                  state;
    state_t                  state_n;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_n;
    logic [SEL_W-1:0]        cur_sel;
    logic                    dropped;
    logic                    locked;
    logic                    ctrl_wr;
    logic [SEL_W-1:0]        ctrl_sel;
    logic                    lock_req;
    logic                    accept;
    logic [NUM_PROJECTS-1:0] sel_onehot;

    project_select_wb_regs #(
        .BASE_ADDR (BASE_ADDR),
        .RESET_SEL (DEF_SEL)
    ) u_regs (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus),
        .cur_sel  (cur_sel),
        .state    (state),
        .busy     (busy_o),
        .dropped  (dropped),
        .locked   (locked),
        .ctrl_wr  (ctrl_wr),
        .ctrl_sel (ctrl_sel),
        .lock_req (lock_req)
    );

    assign accept = ctrl_wr && (state == ST_RUN) && !locked;
    assign busy_o = (state != ST_RUN);

    // State and phase counter register; reset lands in GUARD so the
    // default project comes up through the normal timed sequence
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_GUARD;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_n = '0;
                if (!bus.wb_cyc_i) begin
                    state_n = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_n = ST_PRST;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_PRST: begin
                if (cnt == RESET_LAST) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_GUARD;
                cnt_n   = '0;
            end
        endcase
    end

    // One-hot decode of the current selection (zero when out of range)
    always_comb begin
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_PROJECTS; i++) begin
            sel_onehot[i] = (cur_sel == 5'(i));
        end
    end

    // Active lines and project resets per phase
    always_comb begin
        active_o   = '0;
        proj_rst_o = '1;
        case (state)
            ST_RUN: begin
                active_o   = sel_onehot;
                proj_rst_o = ~sel_onehot;
            end
            ST_PRST: begin
                active_o   = sel_onehot;
            end
            default: begin
                active_o   = '0;
                proj_rst_o = '1;
            end
        endcase
    end

    // Selection capture and sticky dropped-request flag
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cur_sel <= DEF_SEL;
            dropped <= 1'b0;
        end else if (accept) begin
            cur_sel <= ctrl_sel;
            dropped <= 1'b0;
        end else if (ctrl_wr) begin
            dropped <= 1'b1;
        end
    end

`ifdef PROJ_SEL_LOCK_EN
    // Lock is one-way; only wb_rst_i clears it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            locked <= 1'b0;
        end else if (lock_req) begin
            locked <= 1'b1;
        end
    end
`else
    logic unused_lock_req;
    assign unused_lock_req = lock_req;
    assign locked          = 1'b0;
`endif

endmodule

// File: tb/tb_project_select_ctrl.sv
// Randomized self-checking bench for project_select_ctrl against a
// timeline-based reference model. Honours PROJ_SEL_LOCK_EN when defined.
module tb_project_select_ctrl;

    localparam int          NP   = 8;
    localparam int          G    = 4;
    localparam int          R    = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] DMASK = 32'hFFFF_F8FF;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic [NP-1:0] active_o;
    logic [NP-1:0] proj_rst_o;
    logic          busy_o;

    project_select_if bus ();

    project_select_ctrl #(
        .NUM_PROJECTS (NP),
        .BASE_ADDR    (BASE),
        .DEFAULT_SEL  (0),
        .GUARD_CYCLES (G),
        .RESET_CYCLES (R)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .bus        (bus),
        .active_o   (active_o),
        .proj_rst_o (proj_rst_o),
        .busy_o     (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the switchover is a timeline anchored at the cycle GUARD begins
    int          n;
    int          m_gstart;
    bit          m_drain;
    int          m_sel;
    int          m_pend;
    bit          m_dropped;
    bit          m_locked;
    bit          m_ack;
    logic [31:0] m_dat;

    bit          got_ack;
    logic [31:0] last_rd;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int s);
        logic [NP-1:0] r;
        r = '0;
        if (s >= 0 && s < NP) r[s] = 1'b1;
        return r;
    endfunction

    function automatic bit m_busy();
        return m_drain || (n < m_gstart + G + R);
    endfunction

    function automatic logic [NP-1:0] exp_active();
        if (m_drain || n < m_gstart + G) return '0;
        return onehot(m_sel);
    endfunction

    function automatic logic [NP-1:0] exp_rst();
        if (!m_drain && n >= m_gstart + G + R) return ~onehot(m_sel);
        return '1;
    endfunction

    // Advance the model over one clock edge using the inputs now on the bus
    task automatic model_edge();
        bit          hit_c, hit_s, req, busy_now;
        logic [31:0] a, st;
        a     = bus.wbs_addr_i & 32'hFFFF_FFFC;
        hit_c = (a == BASE);
        hit_s = (a == BASE + 32'd4);
        req   = bus.wb_cyc_i && bus.wb_stb_i && (hit_c || hit_s) && !m_ack;
        if (wb_rst_i) begin
            n = 0; m_gstart = 0; m_drain = 0; m_sel = 0; m_pend = 0;
            m_dropped = 0; m_locked = 0; m_ack = 0; m_dat = '0;
            return;
        end
        busy_now = m_busy();
        st = 32'(m_sel) | (32'(busy_now) << 11) | (32'(m_dropped) << 12) | (32'(m_locked) << 13);
        m_dat = '0;
        if (req && !bus.wbs_we_i) m_dat = hit_c ? 32'(m_pend) : st;
        if (m_drain && !bus.wb_cyc_i) begin
            m_drain  = 0;
            m_gstart = n + 1;
        end
        if (req && bus.wbs_we_i && hit_c && bus.wbs_sel_i[0]) begin
            m_pend = int'(bus.wbs_dat_i & 32'h1F);
            if (!busy_now && !m_locked) begin
                m_sel     = m_pend;
                m_drain   = 1;
                m_dropped = 0;
            end else begin
                m_dropped = 1;
            end
        end
`ifdef PROJ_SEL_LOCK_EN
        if (req && bus.wbs_we_i && hit_c && bus.wbs_sel_i[3] && bus.wbs_dat_i[31]) m_locked = 1;
`endif
        m_ack = req;
        n++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge wb_clk_i);
        #1;
        check_value("active", 32'(active_o), 32'(exp_active()));
        check_value("proj_rst", 32'(proj_rst_o), 32'(exp_rst()));
        check_value("busy", 32'(busy_o), 32'(m_busy()));
        check_value("ack", 32'(bus.wbs_ack_o), 32'(m_ack));
        check_value("dat_o", bus.wbs_dat_o & DMASK, m_dat & DMASK);
    endtask

    task automatic do_reset(input int cycles);
        wb_rst_i = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        repeat (cycles) tick();
        wb_rst_i = 1'b0;
    endtask

    task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w, input int hold);
        bus.wb_cyc_i   = 1'b1;
        bus.wb_stb_i   = 1'b1;
        bus.wbs_we_i   = w;
        bus.wbs_sel_i  = s;
        bus.wbs_dat_i  = d;
        bus.wbs_addr_i = a;
        got_ack = 0;
        last_rd = '0;
        for (int i = 0; i < 3 && !got_ack; i++) begin
            tick();
            if (bus.wbs_ack_o) begin
                got_ack = 1;
                last_rd = bus.wbs_dat_o;
            end
        end
        bus.wb_stb_i = 1'b0;
        bus.wbs_we_i = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        bus.wb_cyc_i = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy_o; i++) tick();
        check_value("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_i       = 1'b1;
        bus.wb_cyc_i   = 1'b0;
        bus.wb_stb_i   = 1'b0;
        bus.wbs_we_i   = 1'b0;
        bus.wbs_sel_i  = 4'h0;
        bus.wbs_dat_i  = '0;
        bus.wbs_addr_i = '0;
        m_ack = 0;
        n = 0;

        // 1: reset bring-up of the default project
        do_reset(2);
        check_value("t1_rst_active", 32'(active_o), 32'h00);
        check_value("t1_rst_prst", 32'(proj_rst_o), 32'hFF);
        check_value("t1_rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        repeat (4) tick();
        check_value("t1_active_c5", 32'(active_o), 32'h01);
        check_value("t1_rst_held", 32'(proj_rst_o), 32'hFF);
        repeat (7) tick();
        check_value("t1_rst_c12", 32'(proj_rst_o), 32'hFF);
        tick();
        check_value("t1_rst_fall", 32'(proj_rst_o), 32'hFE);
        check_value("t1_busy_low", 32'(busy_o), 32'd0);

        // 2: switch to project 3 with cyc held 2 cycles after ack
        wb_access(BASE, 32'd3, 4'hF, 1'b1, 2);
        check_value("t2_ack", 32'(got_ack), 32'd1);
        wait_idle();
        check_value("t2_active", 32'(active_o), 32'h08);
        check_value("t2_rst", 32'(proj_rst_o), 32'hF7);

        // 3: write during PRST is dropped, next accepted write clears the flag
        wb_access(BASE, 32'd5, 4'hF, 1'b1, 0);
        for (int i = 0; i < 50 && active_o == '0; i++) tick();
        check_value("t3_in_prst", 32'(busy_o), 32'd1);
        wb_access(BASE, 32'd3, 4'hF, 1'b1, 0);
        check_value("t3_drop_ack", 32'(got_ack), 32'd1);
        wb_access(BASE + 32'd4, 32'd0, 4'hF, 1'b0, 0);
        check_value("t3_dropped", 32'(last_rd[12]), 32'd1);
        check_value("t3_cur_sel", 32'(last_rd[4:0]), 32'd5);
        wait_idle();
        check_value("t3_active", 32'(active_o), 32'h20);
        wb_access(BASE, 32'd1, 4'hF, 1'b1, 0);
        wait_idle();
        wb_access(BASE + 32'd4, 32'd0, 4'hF, 1'b0, 0);
        check_value("t3_drop_clr", 32'(last_rd[12]), 32'd0);
        check_value("t3_sel1", 32'(last_rd[4:0]), 32'd1);

        // 4: selecting none
        wb_access(BASE, 32'd31, 4'hF, 1'b1, 1);
        wait_idle();
        check_value("t4_active", 32'(active_o), 32'h00);
        check_value("t4_rst", 32'(proj_rst_o), 32'hFF);

        // 5: foreign addresses and write without sel[0]
        wb_access(BASE, 32'd2, 4'hF, 1'b1, 0);
        wait_idle();
        wb_access(BASE + 32'd8, 32'd7, 4'hF, 1'b1, 0);
        check_value("t5_miss8_ack", 32'(got_ack), 32'd0);
        wb_access(32'h3000_1000, 32'd0, 4'hF, 1'b0, 0);
        check_value("t5_miss1000_ack", 32'(got_ack), 32'd0);
        check_value("t5_active", 32'(active_o), 32'h04);
        wb_access(BASE, 32'd6, 4'b0010, 1'b1, 0);
        check_value("t5_sel_ack", 32'(got_ack), 32'd1);
        check_value("t5_no_switch", 32'(busy_o), 32'd0);
        wb_access(BASE + 32'd4, 32'd0, 4'hF, 1'b0, 0);
        check_value("t5_no_drop", 32'(last_rd[12]), 32'd0);

        // 6: lock bit
`ifdef PROJ_SEL_LOCK_EN
        wb_access(BASE, 32'h8000_0002, 4'hF, 1'b1, 0);
        wait_idle();
        check_value("t6_active", 32'(active_o), 32'h04);
        wb_access(BASE, 32'd5, 4'hF, 1'b1, 0);
        wb_access(BASE + 32'd4, 32'd0, 4'hF, 1'b0, 0);
        check_value("t6_locked", 32'(last_rd[13]), 32'd1);
        check_value("t6_dropped", 32'(last_rd[12]), 32'd1);
        check_value("t6_still2", 32'(active_o), 32'h04);
        do_reset(1);
        wait_idle();
        wb_access(BASE + 32'd4, 32'd0, 4'hF, 1'b0, 0);
        check_value("t6_unlock", 32'(last_rd[13]), 32'd0);
`else
        wb_access(BASE, 32'h8000_0006, 4'hF, 1'b1, 0);
        wait_idle();
        wb_access(BASE + 32'd4, 32'd0, 4'hF, 1'b0, 0);
        check_value("t6_nolock", 32'(last_rd[13]), 32'd0);
        check_value("t6_active", 32'(active_o), 32'h40);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 200; it++) begin
            int          op;
            logic [31:0] d;
            logic [3:0]  s;
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                0, 1, 2, 3: begin
                    d[4:0] = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
                    d[31]  = ($urandom_range(0, 11) == 0);
                    s      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                    wb_access(BASE, d, s, 1'b1, $urandom_range(0, 3));
                end
                4: wb_access(BASE, d, 4'hF, 1'b0, $urandom_range(0, 2));
                5: wb_access(BASE + 32'd4 + 32'($urandom_range(0, 3)), d, 4'hF,
                             1'($urandom_range(0, 1)), 0);
                6: wb_access(BASE + 32'h10 + 32'($urandom_range(0, 255) * 4), d, 4'hF,
                             1'($urandom_range(0, 1)), 0);
                7: repeat ($urandom_range(1, 12)) tick();
                8: wait_idle();
                default: begin
                    if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 2));
                    else tick();
                end
            endcase
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
